// File: rtl/cordic_arbiter_if.sv
// Shared types and requester/engine bus for the CORDIC arbiter.
// The interface carries both the requester handshake and the engine-facing payloads.
package cordic_arbiter_pkg;
    localparam int unsigned NUM_STAGE  = 16;
    localparam int unsigned XYZ_IN_W   = 16;
    localparam int unsigned XYZ_OUT_W  = 18;

    typedef enum logic { ROTATION = 1'b0, VECTOR = 1'b1 } cordic_func;

    typedef struct packed {
        logic signed [XYZ_IN_W-1:0] x;
        logic signed [XYZ_IN_W-1:0] y;
        logic signed [XYZ_IN_W-1:0] z;
    } cordic_data_in;

    typedef struct packed {
        logic signed [XYZ_OUT_W-1:0] x;
        logic signed [XYZ_OUT_W-1:0] y;
        logic signed [XYZ_OUT_W-1:0] z;
    } cordic_data;

    typedef struct packed {
        logic          vld;
        cordic_func    func;
        cordic_data_in data;
    } st_cordic_in;

    typedef struct packed {
        logic       vld;
        cordic_data data;
    } st_cordic_out;
endpackage

interface cordic_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import cordic_arbiter_pkg::*;

    logic          [NUM_REQ-1:0] req_vld;
    logic          [NUM_REQ-1:0] req_func;
    cordic_data_in [NUM_REQ-1:0] req_data;
    logic          [NUM_REQ-1:0] req_rdy;
    st_cordic_in                 cordic_in;
    st_cordic_out                cordic_out;
    logic          [NUM_REQ-1:0] rsp_vld;
    cordic_data                  rsp_data;

    // Requesters and engine side.
    modport master (
        output req_vld, req_func, req_data, cordic_out,
        input  req_rdy, cordic_in, rsp_vld, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_vld, req_func, req_data, cordic_out,
        output req_rdy, cordic_in, rsp_vld, rsp_data
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one pipelined CORDIC engine among NUM_REQ requesters.
// A tag pipe matched to the engine latency steers each result back to its issuer.
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CORDIC_LAT = NUM_STAGE,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            err_clr_i,
    cordic_arbiter_if.slave bus,
    output logic            busy_o,
    output logic            err_o
);

    logic                          gnt_vld_c;
    logic [ID_W-1:0]               gnt_id_c;
    logic [ID_W-1:0]               rr_ptr_q,  rr_ptr_d;
    st_cordic_in                   cin_q,     cin_d;
    logic [CORDIC_LAT:0]           tag_vld_q, tag_vld_d;
    logic [CORDIC_LAT:0][ID_W-1:0] tag_id_q,  tag_id_d;
    logic [NUM_REQ-1:0]            rsp_vld_q, rsp_vld_d;
    cordic_data                    rsp_data_q, rsp_data_d;
    logic                          err_q,     err_d;
    logic                          hit_c;
    logic                          mis_c;

    // First pending requester at or above rr_ptr, wrapping; suppressed in reset so outputs clear at once.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_id_c  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_vld_c && bus.req_vld[ID_W'((32'(rr_ptr_q) + k) % NUM_REQ)]) begin
                gnt_vld_c = 1'b1;
                gnt_id_c  = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
        if (!en_i || rst) begin
            gnt_vld_c = 1'b0;
        end
    end

    assign bus.req_rdy = gnt_vld_c ? (NUM_REQ'(1) << gnt_id_c) : '0;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        cin_d         = cin_q;
        cin_d.vld     = gnt_vld_c;
        if (gnt_vld_c) begin
            rr_ptr_d   = ID_W'((32'(gnt_id_c) + 32'd1) % NUM_REQ);
            cin_d.func = cordic_func'(bus.req_func[gnt_id_c]);
            cin_d.data = bus.req_data[gnt_id_c];
        end

        tag_vld_d = {tag_vld_q[CORDIC_LAT-1:0], gnt_vld_c};
        tag_id_d  = {tag_id_q[CORDIC_LAT-1:0],  gnt_id_c};

        // Tag at the pipe end must coincide with an engine result; anything else is misalignment.
        hit_c      = tag_vld_q[CORDIC_LAT] & bus.cordic_out.vld;
        mis_c      = tag_vld_q[CORDIC_LAT] ^ bus.cordic_out.vld;
        rsp_vld_d  = hit_c ? (NUM_REQ'(1) << tag_id_q[CORDIC_LAT]) : '0;
        rsp_data_d = hit_c ? bus.cordic_out.data : rsp_data_q;
        err_d      = mis_c | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            cin_q      <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cin_q      <= cin_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.cordic_in = cin_q;
    assign bus.rsp_vld   = rsp_vld_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy_o        = cin_q.vld | (|tag_vld_q);
    assign err_o         = err_q;

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one pipelined CORDIC engine between NUM_REQ requesters.
- Each requester presents an `st_cordic_in` operation (func + x/y/z) with a valid/ready handshake.
- Arbitration is round-robin; at most one issue per cycle.
- A tag pipeline matched to the engine latency routes each `st_cordic_out` result back to its issuing requester.
- Sits between the request sources and the CORDIC wrapper; also flags issue/return misalignment.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CORDIC_LAT, NUM_STAGE: cycles from `cordic_in.vld` to the matching `cordic_out.vld` at the engine.
- ID_W, $clog2(NUM_REQ): requester id width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  1 = grants allowed; 0 = no new grants, in-flight operations drain.
- req_vld  in  NUM_REQ  per-requester request valid.
- req_func  in  NUM_REQ  per-requester `cordic_func` (0 ROTATION, 1 VECTOR).
- req_data  in  NUM_REQ x 48  per-requester `cordic_data_in` {x,y,z}, 16b signed each.
- req_rdy  out  NUM_REQ  one-hot grant (combinational); transfer when req_vld[i] & req_rdy[i].
- cordic_in  out  50  registered `st_cordic_in` to the engine.
- cordic_out  in  55  `st_cordic_out` from the engine.
- rsp_vld  out  NUM_REQ  one-hot registered result valid to the owning requester.
- rsp_data  out  54  registered `cordic_data` {x,y,z}, 18b signed each, shared by all requesters.
- busy  out  1  any operation issued but not yet returned.
- err  out  1  sticky misalignment flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (async assert, sync release): cordic_in = 0, rsp_vld = 0, rsp_data = 0, err = 0, rr_ptr = 0, tag pipe all invalid, busy = 0.
- Arbitration:
  - Grant the first i with req_vld[i] = 1, searching from rr_ptr upward modulo NUM_REQ.
  - req_rdy[i] is 1 only for that i, and only when en = 1.
  - All req_rdy = 0 when en = 0 or no request is pending.
  - req_rdy does not depend on req_rdy.
- On a grant to requester g in cycle T:
  - rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
  - In cycle T+1: cordic_in.vld = 1, cordic_in.func = req_func[g], cordic_in.data = req_data[g].
  - If cycle T has no grant, cordic_in.vld = 0 in T+1 and the data field holds its previous value.
- Tag pipe:
  - CORDIC_LAT+1 entries of {vld, id}.
  - Entry 0 is loaded alongside the cordic_in register; entries shift by one each cycle.
  - Entry CORDIC_LAT is valid in cycle T+1+CORDIC_LAT.
- Return:
  - In cycle T+1+CORDIC_LAT, if tag[CORDIC_LAT].vld = 1 and cordic_out.vld = 1, then in cycle T+2+CORDIC_LAT: rsp_vld[id] = 1 and rsp_data = cordic_out.data.
  - rsp_vld is a single-cycle pulse. There is no response backpressure; requesters always accept.
  - Total request-to-response latency: CORDIC_LAT+2 cycles.
- Misalignment: if tag[CORDIC_LAT].vld != cordic_out.vld in any cycle:
  - err <= 1 in the next cycle.
  - A valid tag with no result gives no rsp_vld; the operation is dropped.
  - A result with no tag is discarded.
- err_clr:
  - Clears err next cycle.
  - A new mismatch in the same cycle as err_clr wins; err stays 1.
- busy = cordic_in.vld | OR of all tag[k].vld. This is combinational from registers.
- Throughput: one grant per cycle sustained; full pipeline occupancy is allowed.
- en deassert mid-stream: already-issued operations complete and respond normally; rr_ptr holds.
- Reset mid-operation: all in-flight tags are lost. No response is generated for them. Late engine results arriving after reset are discarded and set err (expected; software clears).
- req_data/req_func are sampled only in the grant cycle. Changes while ungranted are ignored.

Test Plan:
- Reset, then single request: NUM_REQ=4, CORDIC_LAT=2, engine model = identity delay 2. req_vld[2]=1, data x=0x1000 y=0 z=0x2000, ROTATION at T0.
  -> req_rdy=4'b0100 at T0; cordic_in.vld at T1; rsp_vld=4'b0100 at T4 with data sign-extended to 18b.
- All four requesting continuously from reset.
  -> grants 0,1,2,3,0,1,... one per cycle; rsp_vld pulses follow the same order, each 4 cycles after its grant; no gaps.
- req_vld = 4'b1010 held, rr_ptr=0.
  -> grants alternate 1,3,1,3. A newly raised req_vld[0] after grant 3 is granted next, ahead of 1.
- en=0 while 2 ops are in flight.
  -> no req_rdy; both responses still arrive; busy falls to 0 the cycle after the last tag leaves; rr_ptr unchanged; grants resume at rr_ptr when en=1.
- Engine injects a spurious cordic_out.vld with no tag, then withholds one expected result.
  -> err=1 the next cycle; no rsp_vld for either case; err_clr pulse -> err=0 the next cycle.
- Assert rst with 3 ops in flight.
  -> all outputs 0 immediately; no rsp_vld after release; rr_ptr=0; the first grant goes to the lowest valid requester.
